// File: rtl/gps_axi_lite_slave_regs.sv
// AXI4-Lite register file for the GPS core: write commits one cycle after the later AW/W handshake,
// reads answer one cycle after AR; each response holds until accepted and blocks new requests on its channel.
module gps_axi_lite_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [NUM_REGS-1:0][DW-1:0] regs;

  logic              ready_en;
  logic              aw_held;
  logic              w_held;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [DW-1:0]     w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [IDX_W-1:0]  wr_idx;
  logic [DW-1:0]     wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_ok;
  logic [IDX_W-1:0]  ar_idx;
  logic              rd_ok;
  logic [DW-1:0]     rd_word;
  logic              unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ready_en keeps all READYs low until the first edge after reset release
  assign S_AXI_AWREADY = ready_en & ~aw_held & ~S_AXI_BVALID;
  assign S_AXI_WREADY  = ready_en & ~w_held  & ~S_AXI_BVALID;
  assign S_AXI_ARREADY = ready_en & ~S_AXI_RVALID;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // Bypass the holding registers so the commit lands on the edge of the later handshake
  assign commit  = (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_held  ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held  ? w_strb_q : S_AXI_WSTRB;
  assign wr_ok   = int'(wr_idx) < NUM_REGS;

  assign ar_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_ok   = int'(ar_idx) < NUM_REGS;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(ar_idx) == k) rd_word = regs[k];
    end
  end

  assign reg_out = regs;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en     <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      reg_wr_pulse <= '0;
      regs         <= '0;
    end else begin
      ready_en     <= 1'b1;
      reg_wr_pulse <= '0;
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (int'(wr_idx) == k && |wr_strb) begin
            reg_wr_pulse[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_strb[b]) regs[k][8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
        if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Read data is sampled at the AR handshake, so a same-cycle write is not visible
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_ok ? rd_word : '0;
      S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule
